// File: rtl/decode_instruction_pkg.sv
// Shared constants for the fetch/decode front end: widths, instruction field
// positions, opcode values and the immediate sign-extension helper.
package decode_instruction_pkg;

  localparam int WORD  = 32;
  localparam int ADDR  = 16;
  localparam int W_OPC = 6;
  localparam int W_OPR = 32;
  localparam int W_RD  = 4;

  localparam int OPC_MSB     = 31;
  localparam int OPC_LSB     = 26;
  localparam int RD_MSB      = 25;
  localparam int RD_LSB      = 22;
  localparam int RS_MSB      = 21;
  localparam int RS_LSB      = 18;
  localparam int IMM_SEL_BIT = 17;
  localparam int IMM_MSB     = 15;
  localparam int IMM_LSB     = 0;
  localparam int W_IMM       = IMM_MSB - IMM_LSB + 1;

  localparam logic [W_OPC-1:0] OPC_NOP = 6'd0;
  localparam logic [W_OPC-1:0] OPC_MOV = 6'd1;
  localparam logic [W_OPC-1:0] OPC_ADD = 6'd2;
  localparam logic [W_OPC-1:0] OPC_SUB = 6'd3;
  localparam logic [W_OPC-1:0] OPC_AND = 6'd4;
  localparam logic [W_OPC-1:0] OPC_OR  = 6'd5;

  function automatic logic [W_OPR-1:0] sext_imm(input logic [W_IMM-1:0] imm);
    return {{(W_OPR-W_IMM){imm[W_IMM-1]}}, imm};
  endfunction

endpackage

// File: rtl/decode_instruction_register_file.sv
// 16-entry register file: one synchronous write port, two combinational read
// ports, asynchronously cleared.
module register_file #(
  parameter int W_OPR = 32,
  parameter int W_RD  = 4,
  parameter int ADDR  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [W_RD-1:0]  wa,
  input  logic [W_OPR-1:0] wd,
  input  logic [W_RD-1:0]  ra0,
  output logic [W_OPR-1:0] rd0,
  input  logic [W_RD-1:0]  ra1,
  output logic [W_OPR-1:0] rd1
);

  logic [ADDR-1:0][W_OPR-1:0] regs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   regs     <= '0;
    else if (we) regs[wa] <= wd;
  end

  assign rd0 = regs[ra0];
  assign rd1 = regs[ra1];

endmodule

// File: rtl/decode_instruction.sv
// Decode stage: register-file read plus a single output register with stall
// hold. Define DECODE_BYPASS_EN to forward same-edge write-back data.
module decode_instruction #(
  parameter int WORD  = decode_instruction_pkg::WORD,
  parameter int W_OPC = decode_instruction_pkg::W_OPC,
  parameter int W_OPR = decode_instruction_pkg::W_OPR,
  parameter int W_RD  = decode_instruction_pkg::W_RD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             v_i,
  input  logic [WORD-1:0]  inst_i,
  input  logic             stall_i,
  output logic             stall_o,
  output logic             v_o,
  output logic [W_OPC-1:0] opecode_o,
  output logic [W_OPR-1:0] opr0_o,
  output logic [W_OPR-1:0] opr1_o,
  output logic [W_RD-1:0]  wb_r_o,
  input  logic             wb_i,
  input  logic [W_RD-1:0]  wb_r_i,
  input  logic [W_OPR-1:0] result_i
);
  import decode_instruction_pkg::*;

  logic [W_OPC-1:0] opc;
  logic [W_RD-1:0]  rd, rs;
  logic             imm_sel;
  logic [W_OPR-1:0] rf_rd0, rf_rd1, rd_val, rs_val, opr1;
  logic             hold;

  assign opc     = inst_i[OPC_MSB:OPC_LSB];
  assign rd      = inst_i[RD_MSB:RD_LSB];
  assign rs      = inst_i[RS_MSB:RS_LSB];
  assign imm_sel = inst_i[IMM_SEL_BIT];

  register_file #(.W_OPR(W_OPR), .W_RD(W_RD), .ADDR(ADDR)) u_rf (
    .clk   (clk),
    .reset (reset),
    .we    (wb_i),
    .wa    (wb_r_i),
    .wd    (result_i),
    .ra0   (rd),
    .rd0   (rf_rd0),
    .ra1   (rs),
    .rd1   (rf_rd1)
  );

`ifdef DECODE_BYPASS_EN
  // Forward the write-back landing on this same edge instead of the stale entry.
  assign rd_val = (wb_i && wb_r_i == rd) ? result_i : rf_rd0;
  assign rs_val = (wb_i && wb_r_i == rs) ? result_i : rf_rd1;
`else
  assign rd_val = rf_rd0;
  assign rs_val = rf_rd1;
`endif

  assign opr1    = imm_sel ? sext_imm(inst_i[IMM_MSB:IMM_LSB]) : rs_val;
  // An empty output register never blocks, even when downstream is stalled.
  assign hold    = stall_i & v_o;
  assign stall_o = hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_o       <= 1'b0;
      opecode_o <= '0;
      opr0_o    <= '0;
      opr1_o    <= '0;
      wb_r_o    <= '0;
    end else if (!hold) begin
      v_o       <= v_i;
      opecode_o <= opc;
      opr0_o    <= rd_val;
      opr1_o    <= opr1;
      wb_r_o    <= rd;
    end
  end

endmodule

// File: tb/tb_decode_instruction.sv
// Self-checking bench for decode_instruction: directed scenarios plus a
// randomized run against a behavioural model of the decode stage.
module tb_decode_instruction;

  logic        clk = 1'b0;
  logic        reset;
  logic        v_i;
  logic [31:0] inst_i;
  logic        stall_i;
  logic        stall_o;
  logic        v_o;
  logic [5:0]  opecode_o;
  logic [31:0] opr0_o, opr1_o;
  logic [3:0]  wb_r_o;
  logic        wb_i;
  logic [3:0]  wb_r_i;
  logic [31:0] result_i;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [31:0] mregs [16];
  logic        mv;
  logic [5:0]  mopc;
  logic [31:0] mopr0, mopr1;
  logic [3:0]  mwb;

  decode_instruction dut (
    .clk(clk), .reset(reset), .v_i(v_i), .inst_i(inst_i), .stall_i(stall_i),
    .stall_o(stall_o), .v_o(v_o), .opecode_o(opecode_o), .opr0_o(opr0_o),
    .opr1_o(opr1_o), .wb_r_o(wb_r_o), .wb_i(wb_i), .wb_r_i(wb_r_i),
    .result_i(result_i)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mregs[i] = 32'd0;
    mv = 1'b0; mopc = '0; mopr0 = '0; mopr1 = '0; mwb = '0;
  endtask

  task automatic drive_idle();
    v_i = 1'b0; inst_i = '0; stall_i = 1'b0;
    wb_i = 1'b0; wb_r_i = '0; result_i = '0;
  endtask

  // Advance the model by one edge using the current inputs, then let the DUT
  // take the same edge and settle.
  task automatic clk_step();
    int rd, rs;
    logic [31:0] a, b;
    rd = int'(inst_i >> 22) % 16;
    rs = int'(inst_i >> 18) % 16;
    a = mregs[rd];
    b = mregs[rs];
`ifdef DECODE_BYPASS_EN
    if (wb_i && int'(wb_r_i) == rd) a = result_i;
    if (wb_i && int'(wb_r_i) == rs) b = result_i;
`endif
    if (!(stall_i && mv)) begin
      mv = v_i;
      if (v_i) begin
        mopc  = 6'(inst_i >> 26);
        mwb   = 4'(rd);
        mopr0 = a;
        mopr1 = inst_i[17] ? 32'(int'($signed(inst_i[15:0]))) : b;
      end
    end
    if (wb_i) mregs[wb_r_i] = result_i;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    model_reset();
    #12;
    vectors++;
    if (v_o !== 1'b0 || opecode_o !== 6'd0 || opr0_o !== 32'd0 || opr1_o !== 32'd0 || wb_r_o !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_state: v=%b opc=%h opr0=%h opr1=%h wb_r=%h required all zero", v_o, opecode_o, opr0_o, opr1_o, wb_r_o);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    // Every register must read zero after reset
    inst_i = {6'd5, 4'd5, 4'd6, 1'b0, 17'd0}; v_i = 1'b1;
    clk_step();
    vectors++;
    if (v_o !== 1'b1 || opr0_o !== 32'd0 || opr1_o !== 32'd0 || opecode_o !== 6'd5) begin
      miscompares++;
      $display("FAIL reset_regs: v=%b opc=%h opr0=%h opr1=%h required 1/05/0/0", v_o, opecode_o, opr0_o, opr1_o);
    end
    drive_idle();
    clk_step();
  endtask

  task automatic test_wb_decode();
    drive_idle();
    wb_i = 1'b1; wb_r_i = 4'd2; result_i = 32'h89ABCDEF;
    clk_step();
    drive_idle();
    v_i = 1'b1; inst_i = 32'h048C0000;
    clk_step();
    vectors++;
    if (v_o !== 1'b1 || opecode_o !== 6'd1 || wb_r_o !== 4'd2 || opr0_o !== 32'h89ABCDEF || opr1_o !== 32'd0) begin
      miscompares++;
      $display("FAIL wb_decode: v=%b opc=%h wb_r=%h opr0=%h opr1=%h required 1/01/2/89abcdef/0", v_o, opecode_o, wb_r_o, opr0_o, opr1_o);
    end
  endtask

  task automatic test_imm();
    drive_idle();
    v_i = 1'b1; inst_i = 32'h08428000;
    clk_step();
    vectors++;
    if (v_o !== 1'b1 || opecode_o !== 6'd2 || wb_r_o !== 4'd1 || opr1_o !== 32'hFFFF8000 || opr0_o !== 32'd0) begin
      miscompares++;
      $display("FAIL imm_sext: v=%b opc=%h wb_r=%h opr0=%h opr1=%h required 1/02/1/0/ffff8000", v_o, opecode_o, wb_r_o, opr0_o, opr1_o);
    end
    // Positive immediate, inst[16] set must be ignored
    inst_i = {6'd4, 4'd3, 4'd9, 1'b1, 1'b1, 16'h1234};
    clk_step();
    vectors++;
    if (opecode_o !== 6'd4 || wb_r_o !== 4'd3 || opr1_o !== 32'h00001234) begin
      miscompares++;
      $display("FAIL imm_pos: opc=%h wb_r=%h opr1=%h required 04/3/00001234", opecode_o, wb_r_o, opr1_o);
    end
  endtask

  task automatic test_stall();
    drive_idle();
    v_i = 1'b1; inst_i = 32'h08428000;
    clk_step();
    stall_i = 1'b1; inst_i = {6'd3, 4'd7, 4'd8, 1'b0, 17'd0};
    // Write to the held instruction's source register must not refresh it
    wb_i = 1'b1; wb_r_i = 4'd1; result_i = 32'hDEADBEEF;
    #1;
    vectors++;
    if (stall_o !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_o_hold: got %b required 1", stall_o);
    end
    for (int c = 0; c < 2; c++) begin
      clk_step();
      wb_i = 1'b0;
      vectors++;
      if (v_o !== 1'b1 || stall_o !== 1'b1 || opecode_o !== 6'd2 || wb_r_o !== 4'd1 || opr0_o !== 32'd0 || opr1_o !== 32'hFFFF8000) begin
        miscompares++;
        $display("FAIL stall_hold%0d: v=%b stall_o=%b opc=%h wb_r=%h opr0=%h opr1=%h required 1/1/02/1/0/ffff8000", c, v_o, stall_o, opecode_o, wb_r_o, opr0_o, opr1_o);
      end
    end
    stall_i = 1'b0;
    #1;
    vectors++;
    if (stall_o !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_release: stall_o=%b required 0", stall_o);
    end
    clk_step();
    vectors++;
    if (v_o !== 1'b1 || opecode_o !== 6'd3 || wb_r_o !== 4'd7) begin
      miscompares++;
      $display("FAIL stall_resume: v=%b opc=%h wb_r=%h required 1/03/7", v_o, opecode_o, wb_r_o);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp0;
`ifdef DECODE_BYPASS_EN
    exp0 = 32'h12345678;
`else
    exp0 = 32'h89ABCDEF;
`endif
    drive_idle();
    wb_i = 1'b1; wb_r_i = 4'd2; result_i = 32'h12345678;
    v_i = 1'b1; inst_i = 32'h048C0000;
    clk_step();
    vectors++;
    if (opr0_o !== exp0) begin
      miscompares++;
      $display("FAIL same_edge_wb: opr0=%h required %h", opr0_o, exp0);
    end
    drive_idle();
    v_i = 1'b1; inst_i = 32'h048C0000;
    clk_step();
    vectors++;
    if (opr0_o !== 32'h12345678) begin
      miscompares++;
      $display("FAIL wb_visible_next: opr0=%h required 12345678", opr0_o);
    end
  endtask

  task automatic test_stall_empty();
    drive_idle();
    clk_step();
    stall_i = 1'b1; v_i = 1'b1; inst_i = {6'd5, 4'd2, 4'd2, 1'b0, 17'd0};
    #1;
    vectors++;
    if (v_o !== 1'b0 || stall_o !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_stall_o: v=%b stall_o=%b required 0/0", v_o, stall_o);
    end
    clk_step();
    vectors++;
    if (v_o !== 1'b1 || opecode_o !== 6'd5 || stall_o !== 1'b1 || opr0_o !== 32'h12345678) begin
      miscompares++;
      $display("FAIL empty_capture: v=%b opc=%h stall_o=%b opr0=%h required 1/05/1/12345678", v_o, opecode_o, stall_o, opr0_o);
    end
  endtask

  task automatic test_reset_midrun();
    drive_idle();
    v_i = 1'b1; inst_i = 32'h048C0000;
    clk_step();
    #2;
    reset = 1'b1;
    wb_i = 1'b1; wb_r_i = 4'd4; result_i = 32'hA5A5A5A5;
    #1;
    vectors++;
    if (v_o !== 1'b0 || opecode_o !== 6'd0 || opr0_o !== 32'd0 || opr1_o !== 32'd0 || wb_r_o !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_async: v=%b opc=%h opr0=%h opr1=%h wb_r=%h required all zero", v_o, opecode_o, opr0_o, opr1_o, wb_r_o);
    end
    @(posedge clk); #1;
    model_reset();
    drive_idle();
    reset = 1'b0;
    v_i = 1'b1; inst_i = {6'd1, 4'd2, 4'd4, 1'b0, 17'd0};
    clk_step();
    vectors++;
    if (v_o !== 1'b1 || opr0_o !== 32'd0 || opr1_o !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_dominates: v=%b opr0=%h opr1=%h required 1/0/0", v_o, opr0_o, opr1_o);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      v_i      = ($urandom_range(0, 3) != 0);
      stall_i  = ($urandom_range(0, 2) == 0);
      wb_i     = ($urandom_range(0, 1) == 1);
      wb_r_i   = 4'($urandom_range(0, 15));
      result_i = $urandom;
      inst_i   = $urandom;
      #1;
      vectors++;
      if (stall_o !== (stall_i & mv)) begin
        miscompares++;
        $display("FAIL rand_stall_o[%0d]: got %b required %b", n, stall_o, stall_i & mv);
      end
      clk_step();
      vectors++;
      if (v_o !== mv) begin
        miscompares++;
        $display("FAIL rand_v[%0d]: got %b required %b", n, v_o, mv);
      end else if (mv && (opecode_o !== mopc || wb_r_o !== mwb || opr0_o !== mopr0 || opr1_o !== mopr1)) begin
        miscompares++;
        $display("FAIL rand_data[%0d]: opc=%h wb_r=%h opr0=%h opr1=%h required %h/%h/%h/%h", n, opecode_o, wb_r_o, opr0_o, opr1_o, mopc, mwb, mopr0, mopr1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wb_decode();
    test_imm();
    test_stall();
    test_bypass();
    test_stall_empty();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
